// File: rtl/or1200_except_vec_pkg.sv
// Shared types and constants for the exception vector unit: FSM states, exception codes,
// supervision-register bit positions and reset/base constants.
package or1200_except_vec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSave,
    StIssue,
    StRfe
  } state_e;

  typedef enum logic [3:0] {
    ExcNone     = 4'h0,
    ExcReset    = 4'h1,
    ExcBusErr   = 4'h2,
    ExcDpf      = 4'h3,
    ExcIpf      = 4'h4,
    ExcTick     = 4'h5,
    ExcAlign    = 4'h6,
    ExcIllegal  = 4'h7,
    ExcInt      = 4'h8,
    ExcDtlbMiss = 4'h9,
    ExcItlbMiss = 4'ha,
    ExcRange    = 4'hb,
    ExcSyscall  = 4'hc,
    ExcFpu      = 4'hd,
    ExcTrap     = 4'he
  } except_type_e;

  localparam int unsigned SrSm  = 0;
  localparam int unsigned SrTee = 1;
  localparam int unsigned SrIee = 2;
  localparam int unsigned SrDme = 5;
  localparam int unsigned SrIme = 6;
  localparam int unsigned SrDsx = 13;
  localparam int unsigned SrEph = 14;

  // Bits forced on / forced off when entering a handler.
  localparam logic [15:0] SrSetMask = 16'h0001;
  localparam logic [15:0] SrClrMask = 16'h2066;

  localparam logic [15:0] EsrRst  = 16'h8001;
  localparam logic [31:0] EphBase = 32'hF000_0000;

endpackage

// File: rtl/or1200_except_vec_if.sv
// Vector handshake between the exception unit (master) and the PC generator (slave).
interface or1200_except_vec_if;

  logic        vec_valid_o;
  logic [31:0] vec_addr_o;
  logic        genpc_ready_i;

  modport master (
    output vec_valid_o,
    output vec_addr_o,
    input  genpc_ready_i
  );

  modport slave (
    input  vec_valid_o,
    input  vec_addr_o,
    output genpc_ready_i
  );

endinterface

// File: rtl/or1200_except_vec_sr.sv
// Combinational SR value written on handler entry: supervisor mode on, interrupts,
// tick timer, MMUs and delay-slot flag off, everything else kept from the saved SR.
module or1200_except_vec_sr
  import or1200_except_vec_pkg::*;
(
  input  logic [15:0] esr_i,
  output logic [15:0] sr_o
);

  assign sr_o = (esr_i | SrSetMask) & ~SrClrMask;

endmodule

// File: rtl/or1200_except_vec.sv
// Exception vector unit: saves context, rewrites SR, offers the handler vector, and
// restores SR on l.rfe. Define OR1200_EXCEPT_VEC_EPH_EN to honour SR.EPH (high vector base).
module or1200_except_vec
  import or1200_except_vec_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        except_start,
  input  logic [3:0]                  except_type,
  input  logic [31:0]                 epcr_i,
  input  logic [31:0]                 eear_i,
  input  logic [15:0]                 sr_i,
  input  logic                        rfe_i,
  or1200_except_vec_if.master         vec,
  output logic [31:0]                 epcr_o,
  output logic [31:0]                 eear_o,
  output logic [15:0]                 esr_o,
  output logic                        sr_we_o,
  output logic [15:0]                 sr_o,
  output logic                        busy_o,
  output logic                        overrun_o
);

  state_e      state_q, state_d;
  logic [31:0] epcr_q, epcr_d, eear_q, eear_d;
  logic [15:0] esr_q, esr_d;
  logic [3:0]  type_q, type_d;
  logic        overrun_q, overrun_d;
  logic [15:0] sr_save;
  logic [31:0] base;
  logic        take_exc;

  or1200_except_vec_sr u_sr (
    .esr_i (esr_q),
    .sr_o  (sr_save)
  );

  assign take_exc = except_start && (except_type != ExcNone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      epcr_q    <= '0;
      eear_q    <= '0;
      esr_q     <= EsrRst;
      type_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epcr_q    <= epcr_d;
      eear_q    <= eear_d;
      esr_q     <= esr_d;
      type_q    <= type_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    epcr_d    = epcr_q;
    eear_d    = eear_q;
    esr_d     = esr_q;
    type_d    = type_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (take_exc) begin
          state_d = StSave;
          epcr_d  = epcr_i;
          eear_d  = eear_i;
          esr_d   = sr_i;
          type_d  = except_type;
        end else if (rfe_i && !except_start) begin
          state_d = StRfe;
        end
      end
      StSave:  state_d = StIssue;
      StIssue: if (vec.genpc_ready_i) state_d = StIdle;
      StRfe:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A start arriving while busy cannot be serviced; remember it until reset.
    if (except_start && (state_q != StIdle)) overrun_d = 1'b1;
  end

`ifdef OR1200_EXCEPT_VEC_EPH_EN
  assign base = esr_q[SrEph] ? EphBase : 32'h0;
`else
  assign base = 32'h0;
`endif

  always_comb begin
    vec.vec_valid_o = 1'b0;
    vec.vec_addr_o  = '0;
    sr_we_o         = 1'b0;
    sr_o            = '0;
    unique case (state_q)
      StSave: begin
        sr_we_o = 1'b1;
        sr_o    = sr_save;
      end
      StIssue: begin
        vec.vec_valid_o = 1'b1;
        vec.vec_addr_o  = base | {20'h0, type_q, 8'h00};
      end
      StRfe: begin
        sr_we_o = 1'b1;
        sr_o    = esr_q;
      end
      default: ;
    endcase
  end

  assign epcr_o    = epcr_q;
  assign eear_o    = eear_q;
  assign esr_o     = esr_q;
  assign busy_o    = (state_q != StIdle);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_or1200_except_vec.sv
// Directed self-checking bench for or1200_except_vec; expected values are hand-computed.
module tb_or1200_except_vec;

  logic        clk;
  logic        rst;
  logic        except_start;
  logic [3:0]  except_type;
  logic [31:0] epcr_i;
  logic [31:0] eear_i;
  logic [15:0] sr_i;
  logic        rfe_i;
  logic [31:0] epcr_o;
  logic [31:0] eear_o;
  logic [15:0] esr_o;
  logic        sr_we_o;
  logic [15:0] sr_o;
  logic        busy_o;
  logic        overrun_o;

  int unsigned n_pass;
  int unsigned n_total;

  or1200_except_vec_if vec_if ();

  or1200_except_vec dut (
    .clk          (clk),
    .rst          (rst),
    .except_start (except_start),
    .except_type  (except_type),
    .epcr_i       (epcr_i),
    .eear_i       (eear_i),
    .sr_i         (sr_i),
    .rfe_i        (rfe_i),
    .vec          (vec_if.master),
    .epcr_o       (epcr_o),
    .eear_o       (eear_o),
    .esr_o        (esr_o),
    .sr_we_o      (sr_we_o),
    .sr_o         (sr_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and settle 1 ns past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    except_start = 1'b0;
    except_type  = 4'h0;
    epcr_i = '0;
    eear_i = '0;
    sr_i   = '0;
    rfe_i  = 1'b0;
    vec_if.genpc_ready_i = 1'b1;
    step();
    step();

    chk("rst_epcr", epcr_o, 32'h0);
    chk("rst_eear", eear_o, 32'h0);
    chk("rst_esr", {16'h0, esr_o}, 32'h8001);
    chk("rst_valid", {31'h0, vec_if.vec_valid_o}, 32'h0);
    chk("rst_addr", vec_if.vec_addr_o, 32'h0);
    chk("rst_srwe", {31'h0, sr_we_o}, 32'h0);
    chk("rst_sr", {16'h0, sr_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_ovr", {31'h0, overrun_o}, 32'h0);
    rst = 1'b0;
    step();

    // Alignment exception with ready asserted.
    except_start = 1'b1; except_type = 4'h6;
    epcr_i = 32'h1234; eear_i = 32'hABCD; sr_i = 16'h0007;
    step();
    except_start = 1'b0;
    chk("save_srwe", {31'h0, sr_we_o}, 32'h1);
    chk("save_sr", {16'h0, sr_o}, 32'h0001);
    chk("save_esr", {16'h0, esr_o}, 32'h0007);
    chk("save_eear", eear_o, 32'hABCD);
    chk("save_valid", {31'h0, vec_if.vec_valid_o}, 32'h0);
    chk("save_busy", {31'h0, busy_o}, 32'h1);
    step();
    chk("iss6_valid", {31'h0, vec_if.vec_valid_o}, 32'h1);
    chk("iss6_addr", vec_if.vec_addr_o, 32'h600);
    chk("iss6_epcr", epcr_o, 32'h1234);
    chk("iss6_srwe", {31'h0, sr_we_o}, 32'h0);
    step();
    chk("ret6_valid", {31'h0, vec_if.vec_valid_o}, 32'h0);
    chk("ret6_addr", vec_if.vec_addr_o, 32'h0);
    chk("ret6_busy", {31'h0, busy_o}, 32'h0);

    // Tick exception followed by l.rfe restoring the saved SR.
    except_start = 1'b1; except_type = 4'h5; sr_i = 16'h0007;
    step();
    except_start = 1'b0; sr_i = 16'h00F0;
    step();
    step();
    chk("tick_esr", {16'h0, esr_o}, 32'h0007);
    rfe_i = 1'b1;
    step();
    rfe_i = 1'b0;
    chk("rfe_srwe", {31'h0, sr_we_o}, 32'h1);
    chk("rfe_sr", {16'h0, sr_o}, 32'h0007);
    chk("rfe_busy", {31'h0, busy_o}, 32'h1);
    step();
    chk("rfe_done_srwe", {31'h0, sr_we_o}, 32'h0);
    chk("rfe_done_busy", {31'h0, busy_o}, 32'h0);

    // Interrupt with the PC generator stalled for five cycles.
    vec_if.genpc_ready_i = 1'b0;
    except_start = 1'b1; except_type = 4'h8; sr_i = 16'h0000;
    step();
    except_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall_valid%0d", i), {31'h0, vec_if.vec_valid_o}, 32'h1);
      chk($sformatf("stall_addr%0d", i), vec_if.vec_addr_o, 32'h800);
    end
    vec_if.genpc_ready_i = 1'b1;
    step();
    chk("stall_rel_valid", {31'h0, vec_if.vec_valid_o}, 32'h0);

    // Start and rfe together: exception wins; then a second start while issuing.
    vec_if.genpc_ready_i = 1'b0;
    except_start = 1'b1; rfe_i = 1'b1; except_type = 4'h3;
    epcr_i = 32'h0100; sr_i = 16'h0000;
    step();
    except_start = 1'b0; rfe_i = 1'b0;
    chk("both_sr", {16'h0, sr_o}, 32'h0001);
    chk("both_epcr", epcr_o, 32'h0100);
    step();
    chk("both_addr", vec_if.vec_addr_o, 32'h300);
    except_start = 1'b1; except_type = 4'h7; epcr_i = 32'h0999; rfe_i = 1'b1;
    step();
    except_start = 1'b0; rfe_i = 1'b0;
    chk("ovr_flag", {31'h0, overrun_o}, 32'h1);
    chk("ovr_epcr", epcr_o, 32'h0100);
    chk("ovr_addr", vec_if.vec_addr_o, 32'h300);
    chk("ovr_srwe", {31'h0, sr_we_o}, 32'h0);
    step();
    chk("ovr_sticky", {31'h0, overrun_o}, 32'h1);

    // Reset while a vector is pending.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstiss_valid", {31'h0, vec_if.vec_valid_o}, 32'h0);
    chk("rstiss_esr", {16'h0, esr_o}, 32'h8001);
    chk("rstiss_busy", {31'h0, busy_o}, 32'h0);
    chk("rstiss_ovr", {31'h0, overrun_o}, 32'h0);
    vec_if.genpc_ready_i = 1'b1;

    // Syscall with EPH set: vector base depends on build option.
    except_start = 1'b1; except_type = 4'hc; epcr_i = 32'h2000; sr_i = 16'h4000;
    step();
    except_start = 1'b0;
    chk("eph_sr", {16'h0, sr_o}, 32'h4001);
    step();
`ifdef OR1200_EXCEPT_VEC_EPH_EN
    chk("eph_addr", vec_if.vec_addr_o, 32'hF000_0C00);
`else
    chk("eph_addr", vec_if.vec_addr_o, 32'h0000_0C00);
`endif
    step();

    // NONE code is not an exception: no state change, no register update.
    except_start = 1'b1; except_type = 4'h0; epcr_i = 32'h5555; sr_i = 16'h1111;
    step();
    except_start = 1'b0;
    chk("none_busy", {31'h0, busy_o}, 32'h0);
    chk("none_epcr", epcr_o, 32'h2000);
    chk("none_esr", {16'h0, esr_o}, 32'h4000);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/or1200_except_vec.md
OR1200_EXCEPT_VEC -- requirements
Module: or1200_except_vec

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-003 SHALL have port: except_start  input  1  one-cycle pulse from exception FSM on IDLE->FLU1 exit.
REQ-004 SHALL have port: except_type  input  4  exception code, valid with except_start.
REQ-005 SHALL have port: epcr_i  input  32  saved PC, valid with except_start.
REQ-006 SHALL have port: eear_i  input  32  effective address, valid with except_start.
REQ-007 SHALL have port: sr_i  input  16  current supervision register.
REQ-008 SHALL have port: rfe_i  input  1  one-cycle pulse, l.rfe retired.
REQ-009 SHALL have port: genpc_ready_i  input  1  PC generator accepts vector this cycle.
REQ-010 SHALL have port: vec_valid_o  output  1  vector address offered.
REQ-011 SHALL have port: vec_addr_o  output  32  handler vector address.
REQ-012 SHALL have ports: epcr_o  output  32, eear_o  output  32, esr_o  output  16  shadow registers.
REQ-013 SHALL have ports: sr_we_o  output  1, sr_o  output  16  SR write-back.
REQ-014 SHALL have ports: busy_o  output  1  state != IDLE; overrun_o  output  1  sticky, start lost.

Function
REQ-015 SHALL implement FSM states IDLE, SAVE, ISSUE, RFE.
REQ-016 IDLE, except_start=1, except_type!=NONE(4'h0) -> SAVE; epcr_o/eear_o <= inputs, esr_o <= sr_i, type latched, same edge.
REQ-017 IDLE, except_start=1, except_type==NONE -> stay IDLE, no register update.
REQ-018 SAVE: sr_we_o=1 for exactly one cycle; sr_o = esr_o with SM(bit0)=1, TEE(1)=0, IEE(2)=0, DME(5)=0, IME(6)=0, DSX(13)=0, other bits unchanged; next ISSUE.
REQ-019 ISSUE: vec_valid_o=1, vec_addr_o stable; genpc_ready_i=1 -> IDLE next cycle; else hold ISSUE indefinitely.
REQ-020 vec_addr_o SHALL = base | {20'h0, latched type, 8'h00}; vec_addr_o = 0 when vec_valid_o=0.
REQ-021 Latency: except_start to vec_valid_o = 2 cycles minimum.
REQ-022 IDLE, rfe_i=1, no except_start -> RFE; RFE: sr_we_o=1, sr_o=esr_o, one cycle, then IDLE.
REQ-023 except_start and rfe_i same cycle in IDLE: exception taken, rfe dropped.
REQ-024 except_start or rfe_i outside IDLE: ignored, shadow registers unchanged; lost except_start sets overrun_o until rst.
REQ-025 sr_we_o=0 and sr_o=0 in IDLE and ISSUE.

Reset
REQ-026 rst=1 at any state -> IDLE next edge; pending vector abandoned.
REQ-027 Reset values: epcr_o=0, eear_o=0, esr_o=16'h8001, vec_valid_o=0, vec_addr_o=0, sr_we_o=0, sr_o=0, busy_o=0, overrun_o=0.

Configuration
REQ-028 Macro OR1200_EXCEPT_VEC_EPH_EN defined: base = 32'hF000_0000 when latched sr_i bit14 (EPH) = 1, else 0.
REQ-029 Macro undefined: base = 0 always; EPH bit ignored; no extra flop.

Structure
REQ-030 Shared package SHALL hold FSM state enum, 4-bit except-type codes (NONE..TRAP), SR bit indices, ESR reset value, EPH base constant.
REQ-031 One sub-module or1200_except_vec_sr: combinational SR-mask function for SAVE; all else flat.

Verification
REQ-032 start, type=4'h6, epcr_i=32'h1234, sr_i=16'h0007, ready=1 -> cycle+1 sr_we_o=1, sr_o=16'h0001; cycle+2 vec_addr_o=32'h600, epcr_o=32'h1234.
REQ-033 start, type=4'h8, ready=0 for 5 cycles -> vec_valid_o high 5 cycles at 32'h800, then low one cycle after ready=1.
REQ-034 start and rfe_i same cycle -> exception path, no RFE SR write; second start during ISSUE -> overrun_o=1, epcr_o unchanged.
REQ-035 After type=4'h5 handled with esr_o=16'h0007, rfe_i -> next cycle sr_we_o=1, sr_o=16'h0007.
REQ-036 rst asserted in ISSUE -> next cycle vec_valid_o=0, esr_o=16'h8001, busy_o=0.
REQ-037 With OR1200_EXCEPT_VEC_EPH_EN, sr_i=16'h4000, type=4'hc -> vec_addr_o=32'hF000_0C00; without macro -> 32'h0000_0C00.
